pueo_beam_thresh_sequencer: RTL and testbench
=============================================

Name: pueo_beam_thresh_sequencer

Overview:
Controller that owns the threshold-load interface of a bank of dual beam DSP comparators. Software or a register block writes per-beam thresholds into a shadow register file. On request, the block replays them onto the shared thresh/thresh_ce bus one beam per cycle, then issues a single global update strobe so that all comparators switch thresholds on the same clock. It sits between the register/AXI-lite layer and the NPAIRS dual beam DSP instances.

Parameters:
NPAIRS, 4, number of dual beam DSP instances driven; 2*NPAIRS beams in total.
THRESH_W, 18, threshold width; matches the DSP thresh input.
THRESH_RST, 18'h3FFFF, shadow reset value; maximum threshold, so no triggers fire.
AUTOLOAD, 1, if 1, one load sequence runs automatically after reset release.

Ports:
clk_i  in  1  system clock
rstn_i  in  1  asynchronous, active-low reset
thr_wr_i  in  1  shadow write strobe
thr_addr_i  in  $clog2(2*NPAIRS)  beam index; even 2p = beam A of pair p, odd 2p+1 = beam B of pair p
thr_dat_i  in  THRESH_W  threshold value
load_i  in  1  load request, single-cycle pulse
busy_o  out  1  sequence in progress
done_o  out  1  one-cycle pulse when a sequence completes
wr_drop_o  out  1  one-cycle pulse when a write is dropped
thresh_o  out  THRESH_W  shared threshold bus to all DSPs
thresh_ce_o  out  2*NPAIRS  per-beam load enables; bit 2p+1 = pair p beam A, bit 2p = pair p beam B
update_o  out  1  global update strobe to all DSPs

Behaviour:
- Reset (asynchronous, active-low):
  - All outputs go to 0.
  - State goes to IDLE, pending flag clears, all shadow entries load THRESH_RST.
  - Reset asserted mid-sequence aborts it immediately; no update_o is issued.
- States: IDLE, LOAD, UPDATE, DONE.
- IDLE:
  - Go to LOAD on (load_i | pending | autoload_arm); clear pending and autoload_arm; set k = 0.
  - autoload_arm is set by reset when AUTOLOAD = 1, so LOAD is entered on the first clock edge after reset release.
- LOAD:
  - Each cycle: thresh_o = shadow[k]; thresh_ce_o is one-hot, driving beam k with the mapping A→bit 2p+1, B→bit 2p.
  - Order of k: pair0 A, pair0 B, pair1 A, ...
  - After k = 2*NPAIRS-1, go to UPDATE.
- UPDATE (one cycle):
  - update_o = 1.
  - thresh_o and thresh_ce_o hold the final LOAD word; this is an intentional harmless reload that keeps ce valid while update samples.
- DONE (one cycle):
  - done_o = 1; thresh_ce_o = 0; thresh_o = 0.
  - Return to IDLE.
- Timing:
  - busy_o = 1 in LOAD, UPDATE and DONE.
  - From load_i sampled in IDLE at edge 0: first ce at cycle 1, update_o at cycle 2*NPAIRS+1, done_o at cycle 2*NPAIRS+2.
  - thresh_o, thresh_ce_o and update_o are all registered outputs.
- Outside LOAD and UPDATE: thresh_ce_o = 0, update_o = 0, and thresh_o is held at 0.
- Load requests:
  - load_i while busy sets pending; repeated requests coalesce into one.
  - When pending is set, IDLE lasts exactly one cycle before the next LOAD.
- Shadow writes:
  - Accepted in IDLE only. Written on the edge where thr_wr_i = 1; visible to a load requested in the same cycle.
  - Writes while busy_o = 1 are dropped and pulse wr_drop_o on the next cycle; the shadow is unchanged.
  - thr_addr_i ≥ 2*NPAIRS: write dropped, wr_drop_o pulses.
- Data path: thresh_o passes shadow values bit-exact; no arithmetic, no saturation.

Decomposition:
- Package pueo_thresh_pkg holds:
  - THRESH_W = 18.
  - The state enum type.
  - Beam-to-ce-bit mapping function ce_bit(k) = (k even) ? k+1 : k-1.
- Single module; no natural sub-module. The shadow register file is inline flops, since 2*NPAIRS words is too small for RAM.

Test Plan:
1. NPAIRS=4, AUTOLOAD=1, release reset → busy_o=1 at cycle 1; 8 LOAD cycles with thresh_o=0x3FFFF and ce order 0x02, 0x01, 0x08, 0x04, 0x20, 0x10, 0x80, 0x40; update_o at cycle 9 with ce=0x40; done_o at cycle 10.
2. In IDLE write addr0=0x0A, addr1=0x14, then load_i → cycle 1: thresh_o=0x0A, ce=0x02; cycle 2: thresh_o=0x14, ce=0x01; other beams carry the prior shadow values; a single update_o pulse.
3. Pulse load_i twice during LOAD → exactly one extra sequence; two done_o pulses; one IDLE cycle between the sequences.
4. thr_wr_i addr2=0x00000 while busy → wr_drop_o pulses; the next load shows addr2 unchanged. The same write in IDLE followed by load → thresh_o=0x00000 on ce=0x08.
5. Deassert rstn_i at LOAD k=3 → outputs 0 combinationally with reset; no update_o; after release, the autoload replays all 0x3FFFF values.
6. NPAIRS=3: writes to addr 6 and 7 → dropped with wr_drop_o; write 0x3FFFF and 0x00000 to addr 4 and 5 → passed bit-exact on ce bits 5 and 4.

Source files
------------

// File: rtl/pueo_thresh_pkg.sv
// Shared types and helpers for the beam threshold sequencer: threshold width,
// sequencer state encoding and the beam-index to thresh_ce bit mapping.
package pueo_thresh_pkg;

  localparam int THRESH_W = 18;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_UPDATE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Beam A of a pair (even index) sits on the higher ce bit, beam B on the lower.
  function automatic int unsigned ce_bit(input int unsigned k);
    return ((k % 2) == 0) ? k + 1 : k - 1;
  endfunction

endpackage

// File: rtl/pueo_beam_thresh_sequencer.sv
// Shadow threshold register file plus a sequencer that replays it onto the shared
// thresh/thresh_ce bus one beam per cycle and then fires a single global update.
module pueo_beam_thresh_sequencer
  import pueo_thresh_pkg::*;
#(
  parameter int                   NPAIRS     = 4,
  parameter int                   THRESH_W   = pueo_thresh_pkg::THRESH_W,
  parameter logic [THRESH_W-1:0]  THRESH_RST = {THRESH_W{1'b1}},
  parameter bit                   AUTOLOAD   = 1'b1,
  localparam int                  NB         = 2 * NPAIRS,
  localparam int                  AW         = $clog2(NB)
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                thr_wr_i,
  input  logic [AW-1:0]       thr_addr_i,
  input  logic [THRESH_W-1:0] thr_dat_i,
  input  logic                load_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                wr_drop_o,
  output logic [THRESH_W-1:0] thresh_o,
  output logic [NB-1:0]       thresh_ce_o,
  output logic                update_o,
  output state_e              dbg_state_o
);

  localparam logic [AW:0]   NB_W   = (AW + 1)'(NB);
  localparam logic [AW-1:0] K_LAST = AW'(NB - 1);

  state_e              state_q, state_d;
  logic [AW-1:0]       k_q, k_d;
  logic                pending_q, pending_d;
  logic                arm_q, arm_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                drop_q, drop_d;
  logic                update_q, update_d;
  logic [THRESH_W-1:0] thresh_q, thresh_d;
  logic [NB-1:0]       ce_q, ce_d;
  logic [THRESH_W-1:0] shadow_q [NB];
  logic [THRESH_W-1:0] shadow_d [NB];
  logic                wr_ok;

  function automatic logic [NB-1:0] ce_onehot(input logic [AW-1:0] k);
    return NB'(1) << ce_bit(32'(k));
  endfunction

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    pending_d = pending_q;
    arm_d     = arm_q;
    thresh_d  = thresh_q;
    ce_d      = ce_q;
    update_d  = 1'b0;
    done_d    = 1'b0;
    shadow_d  = shadow_q;

    wr_ok  = thr_wr_i && !busy_q && ({1'b0, thr_addr_i} < NB_W);
    drop_d = thr_wr_i && !wr_ok;
    if (wr_ok) begin
      shadow_d[thr_addr_i] = thr_dat_i;
    end

    if (load_i && busy_q) begin
      pending_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (load_i || pending_q || arm_q) begin
          state_d   = ST_LOAD;
          k_d       = '0;
          pending_d = 1'b0;
          arm_d     = 1'b0;
          // Read through shadow_d so a write in the request cycle is replayed.
          thresh_d  = shadow_d[0];
          ce_d      = ce_onehot('0);
        end
      end
      ST_LOAD: begin
        if (k_q == K_LAST) begin
          // thresh/ce keep the last beam for one more cycle while update samples.
          state_d  = ST_UPDATE;
          update_d = 1'b1;
        end else begin
          k_d      = k_q + 1'b1;
          thresh_d = shadow_q[k_d];
          ce_d     = ce_onehot(k_d);
        end
      end
      ST_UPDATE: begin
        state_d  = ST_DONE;
        done_d   = 1'b1;
        thresh_d = '0;
        ce_d     = '0;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        thresh_d = '0;
        ce_d     = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      pending_q <= 1'b0;
      arm_q     <= AUTOLOAD;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
      update_q  <= 1'b0;
      thresh_q  <= '0;
      ce_q      <= '0;
      for (int i = 0; i < NB; i++) begin
        shadow_q[i] <= THRESH_RST;
      end
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      pending_q <= pending_d;
      arm_q     <= arm_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      drop_q    <= drop_d;
      update_q  <= update_d;
      thresh_q  <= thresh_d;
      ce_q      <= ce_d;
      for (int i = 0; i < NB; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign wr_drop_o   = drop_q;
  assign update_o    = update_q;
  assign thresh_o    = thresh_q;
  assign thresh_ce_o = ce_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pueo_beam_thresh_sequencer.sv
// Bench for the beam threshold sequencer: an expected-output queue model checked
// every cycle on the 4-pair instance, plus directed literal checks on both instances.
module tb_pueo_beam_thresh_sequencer;

  localparam int NB_M = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        thr_wr = 1'b0;
  logic [2:0]  thr_addr = '0;
  logic [17:0] thr_dat = '0;
  logic        load = 1'b0;
  logic        busy, done, wr_drop, update;
  logic [17:0] thresh;
  logic [7:0]  ce;
  logic [1:0]  dbg_state;

  logic        wr3 = 1'b0;
  logic [2:0]  addr3 = '0;
  logic [17:0] dat3 = '0;
  logic        load3 = 1'b0;
  logic        busy3, done3, drop3, update3;
  logic [17:0] thresh3;
  logic [5:0]  ce3;
  logic [1:0]  dbg3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pueo_beam_thresh_sequencer #(.NPAIRS(4), .AUTOLOAD(1'b1)) u_dut (
    .clk_i(clk), .rstn_i(rstn), .thr_wr_i(thr_wr), .thr_addr_i(thr_addr),
    .thr_dat_i(thr_dat), .load_i(load), .busy_o(busy), .done_o(done),
    .wr_drop_o(wr_drop), .thresh_o(thresh), .thresh_ce_o(ce),
    .update_o(update), .dbg_state_o(dbg_state)
  );

  pueo_beam_thresh_sequencer #(.NPAIRS(3), .AUTOLOAD(1'b0)) u_dut3 (
    .clk_i(clk), .rstn_i(rstn), .thr_wr_i(wr3), .thr_addr_i(addr3),
    .thr_dat_i(dat3), .load_i(load3), .busy_o(busy3), .done_o(done3),
    .wr_drop_o(drop3), .thresh_o(thresh3), .thresh_ce_o(ce3),
    .update_o(update3), .dbg_state_o(dbg3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: every accepted request schedules the complete list of per-cycle outputs.
  typedef struct packed {
    logic        busy;
    logic [17:0] thr;
    logic [7:0]  ce;
    logic        upd;
    logic        done;
  } exp_t;

  exp_t        exp_q[$];
  logic [17:0] m_shadow [NB_M];
  logic        m_pending, m_arm, m_drop;
  bit          m_was_busy;
  exp_t        m_e;

  function automatic logic [7:0] beam_ce(input int k);
    int pair;
    pair = k / 2;
    return (k % 2 == 0) ? (8'd1 << (2 * pair + 1)) : (8'd1 << (2 * pair));
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exp_q.delete();
      for (int i = 0; i < NB_M; i++) m_shadow[i] = 18'h3FFFF;
      m_pending = 1'b0;
      m_arm     = 1'b1;
      m_drop    = 1'b0;
    end else begin
      m_was_busy = (exp_q.size() != 0);
      if (m_was_busy) void'(exp_q.pop_front());
      m_drop = thr_wr && (m_was_busy || int'(thr_addr) >= NB_M);
      if (thr_wr && !m_drop) m_shadow[thr_addr] = thr_dat;
      if (m_was_busy) begin
        if (load) m_pending = 1'b1;
      end else if (load || m_pending || m_arm) begin
        m_pending = 1'b0;
        m_arm     = 1'b0;
        for (int k = 0; k < NB_M; k++) exp_q.push_back('{1'b1, m_shadow[k], beam_ce(k), 1'b0, 1'b0});
        exp_q.push_back('{1'b1, m_shadow[NB_M-1], beam_ce(NB_M-1), 1'b1, 1'b0});
        exp_q.push_back('{1'b1, 18'h0, 8'h0, 1'b0, 1'b1});
      end
    end
  end

  always @(negedge clk) begin
    m_e = (exp_q.size() != 0) ? exp_q[0] : '0;
    chk("m_busy",   32'(busy),    32'(m_e.busy));
    chk("m_thresh", 32'(thresh),  32'(m_e.thr));
    chk("m_ce",     32'(ce),      32'(m_e.ce));
    chk("m_update", 32'(update),  32'(m_e.upd));
    chk("m_done",   32'(done),    32'(m_e.done));
    chk("m_drop",   32'(wr_drop), 32'(m_e.done ? 1'b0 : m_drop));
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    chk("wait_idle", 32'(busy), 32'd0);
  endtask

  logic [7:0] exp_ce [8] = '{8'h02, 8'h01, 8'h08, 8'h04, 8'h20, 8'h10, 8'h80, 8'h40};
  int n_done, n_upd, n_gap;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and autoload replay of reset thresholds
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_thresh", 32'(thresh), 32'd0);
    chk("rst_ce", 32'(ce), 32'd0);
    chk("rst_busy3", 32'(busy3), 32'd0);
    #2 rstn = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("auto_busy", 32'(busy), 32'd1);
      chk("auto_thr", 32'(thresh), 32'h3FFFF);
      chk("auto_ce", 32'(ce), 32'(exp_ce[i-1]));
    end
    tick();
    chk("auto_upd", 32'(update), 32'd1);
    chk("auto_upd_ce", 32'(ce), 32'h40);
    tick();
    chk("auto_done", 32'(done), 32'd1);
    chk("auto_done_ce", 32'(ce), 32'd0);
    tick();
    chk("auto_idle", 32'(busy), 32'd0);
    chk("auto3_idle", 32'(busy3), 32'd0);

    // Shadow writes then a load
    thr_wr = 1'b1; thr_addr = 3'd0; thr_dat = 18'h0000A;
    tick();
    thr_addr = 3'd1; thr_dat = 18'h00014;
    tick();
    thr_wr = 1'b0; load = 1'b1;
    tick();
    load = 1'b0;
    chk("wr_thr0", 32'(thresh), 32'h0000A);
    chk("wr_ce0", 32'(ce), 32'h02);
    tick();
    chk("wr_thr1", 32'(thresh), 32'h00014);
    chk("wr_ce1", 32'(ce), 32'h01);
    n_upd = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (update) n_upd++;
    end
    chk("wr_upd_count", 32'(n_upd), 32'd1);
    wait_idle();

    // Two requests during LOAD coalesce into one extra sequence
    load = 1'b1;
    tick();
    load = 1'b0;
    tick(); tick();
    load = 1'b1;
    tick();
    load = 1'b0;
    tick(); tick();
    load = 1'b1;
    tick();
    load = 1'b0;
    n_done = 0; n_upd = 0; n_gap = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) n_done++;
      if (update) n_upd++;
      if (n_done == 1 && !busy) n_gap++;
    end
    chk("coal_done", 32'(n_done), 32'd2);
    chk("coal_upd", 32'(n_upd), 32'd2);
    chk("coal_gap", 32'(n_gap), 32'd1);
    wait_idle();

    // Write while busy is dropped; same write in IDLE with same-cycle load lands
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    thr_wr = 1'b1; thr_addr = 3'd2; thr_dat = 18'h00000;
    tick();
    thr_wr = 1'b0;
    chk("drop_pulse", 32'(wr_drop), 32'd1);
    wait_idle();
    load = 1'b1;
    tick();
    load = 1'b0;
    tick(); tick();
    chk("drop_kept_thr", 32'(thresh), 32'h3FFFF);
    chk("drop_kept_ce", 32'(ce), 32'h08);
    wait_idle();
    thr_wr = 1'b1; thr_addr = 3'd2; thr_dat = 18'h00000; load = 1'b1;
    tick();
    thr_wr = 1'b0; load = 1'b0;
    chk("same_cyc_drop", 32'(wr_drop), 32'd0);
    tick(); tick();
    chk("same_cyc_thr", 32'(thresh), 32'h00000);
    chk("same_cyc_ce", 32'(ce), 32'h08);
    wait_idle();

    // Reset mid-LOAD aborts without update; autoload replays reset values
    load = 1'b1;
    tick();
    load = 1'b0;
    tick(); tick(); tick();
    chk("abort_k3_ce", 32'(ce), 32'h04);
    #2 rstn = 1'b0;
    #1;
    chk("abort_thr", 32'(thresh), 32'd0);
    chk("abort_ce", 32'(ce), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_upd", 32'(update), 32'd0);
    n_upd = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (update) n_upd++;
    end
    chk("abort_no_upd", 32'(n_upd), 32'd0);
    #2 rstn = 1'b1;
    tick();
    chk("reauto_thr0", 32'(thresh), 32'h3FFFF);
    chk("reauto_ce0", 32'(ce), 32'h02);
    tick(); tick();
    chk("reauto_thr2", 32'(thresh), 32'h3FFFF);
    wait_idle();

    // Three-pair instance: out-of-range writes and bit-exact top beams
    chk("p3_idle", 32'(busy3), 32'd0);
    wr3 = 1'b1; addr3 = 3'd6; dat3 = 18'h00005;
    tick();
    addr3 = 3'd7;
    chk("p3_drop6", 32'(drop3), 32'd1);
    tick();
    addr3 = 3'd4; dat3 = 18'h3FFFF;
    chk("p3_drop7", 32'(drop3), 32'd1);
    tick();
    addr3 = 3'd5; dat3 = 18'h00000;
    chk("p3_ok4", 32'(drop3), 32'd0);
    tick();
    wr3 = 1'b0; load3 = 1'b1;
    chk("p3_ok5", 32'(drop3), 32'd0);
    tick();
    load3 = 1'b0;
    chk("p3_ce0", 32'(ce3), 32'h02);
    chk("p3_thr0", 32'(thresh3), 32'h3FFFF);
    repeat (4) tick();
    chk("p3_thr4", 32'(thresh3), 32'h3FFFF);
    chk("p3_ce4", 32'(ce3), 32'h20);
    tick();
    chk("p3_thr5", 32'(thresh3), 32'h00000);
    chk("p3_ce5", 32'(ce3), 32'h10);
    tick();
    chk("p3_upd", 32'(update3), 32'd1);
    chk("p3_upd_ce", 32'(ce3), 32'h10);
    tick();
    chk("p3_done", 32'(done3), 32'd1);
    tick();
    chk("p3_end_idle", 32'(busy3), 32'd0);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
